// File: rtl/if_stage_fetch.sv
// ---------------------------------------------------------------------------
// if_stage_fetch
//
// Instruction-fetch stage of the pipelined LEGv8 CPU. Owns the PC, fetches
// instruction words from instruction memory and loads the IF/ID pipeline
// register. It also drives the ID-stage control unit's opcode input
// (instruction[31:21] of the IF/ID word).
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   stall          hazard unit: hold IF/ID and the PC
//   branch_taken   MEM-stage redirect: flush IF/ID, fetch from branch_target
//   branch_target  redirect address; bits [1:0] are forced to 00
//   imem_req/addr  fetch request and its address
//   imem_ack/rdata memory returns the instruction word this cycle
//   if_id_valid    IF/ID holds a real instruction
//   if_id_pc       PC of the IF/ID instruction
//   if_id_instr    IF/ID instruction word
//   opcode         if_id_instr[31:21] when if_id_valid=1, else 0
//
// Memory handshake: a transfer happens on a rising edge where imem_req=1 and
// imem_ack=1. Once imem_req is raised it stays high with imem_addr unchanged
// until that transfer; there is no cancellation. imem_ack while imem_req=0
// is ignored. imem_ack may be asserted in the same cycle imem_req rises.
// ---------------------------------------------------------------------------
module if_stage_fetch #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic [10:0]       opcode
);

    // FETCH    : request outstanding at pc (except the first cycle after reset)
    // BUFFERED : a word arrived during a stall and waits in buf_q
    // DISCARD  : a redirect hit while a request was in flight; the request
    //            must still complete, its data is dropped, then pc <= pend_q
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_BUFFERED = 2'd1,
        ST_DISCARD  = 2'd2
    } state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic              req_q,     req_d;
    logic [31:0]       buf_q,     buf_d;
    logic [ADDR_W-1:0] buf_pc_q,  buf_pc_d;
    logic [ADDR_W-1:0] pend_q,    pend_d;
    logic              valid_q,   valid_d;
    logic [ADDR_W-1:0] id_pc_q,   id_pc_d;
    logic [31:0]       instr_q,   instr_d;
    logic [10:0]       opcode_q,  opcode_d;

    logic              ack_ok;
    logic [ADDR_W-1:0] target_al;
    logic [ADDR_W-1:0] pc_inc;

    assign ack_ok    = imem_ack & req_q;
    assign target_al = {branch_target[ADDR_W-1:2], 2'b00};
    assign pc_inc    = pc_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        buf_d    = buf_q;
        buf_pc_d = buf_pc_q;
        pend_d   = pend_q;
        valid_d  = valid_q;
        id_pc_d  = id_pc_q;
        instr_d  = instr_q;

        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                if (!req_q) begin
                    // First cycle after reset: no request on the bus yet.
                    if (branch_taken) begin
                        pc_d    = target_al;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end else if (imem_ack) begin
                    if (branch_taken) begin
                        pc_d    = target_al;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        buf_d    = imem_rdata;
                        buf_pc_d = pc_q;
                        pc_d     = pc_inc;
                        req_d    = 1'b0;
                        state_d  = ST_BUFFERED;
                    end else begin
                        valid_d = 1'b1;
                        id_pc_d = pc_q;
                        instr_d = imem_rdata;
                        pc_d    = pc_inc;
                    end
                end else begin
                    if (branch_taken) begin
                        pend_d  = target_al;
                        valid_d = 1'b0;
                        state_d = ST_DISCARD;
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
            end

            ST_BUFFERED: begin
                if (branch_taken) begin
                    pc_d    = target_al;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    id_pc_d = buf_pc_q;
                    instr_d = buf_q;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                valid_d = 1'b0;
                req_d   = 1'b1;
                if (ack_ok) begin
                    // A redirect in the completing cycle beats the pending one.
                    pc_d    = branch_taken ? target_al : pend_q;
                    state_d = ST_FETCH;
                end else if (branch_taken) begin
                    pend_d = target_al;
                end
            end

            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                valid_d = 1'b0;
            end
        endcase

        opcode_d = valid_d ? instr_d[31:21] : 11'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            buf_q    <= '0;
            buf_pc_q <= '0;
            pend_q   <= '0;
            valid_q  <= 1'b0;
            id_pc_q  <= '0;
            instr_q  <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            id_pc_q  <= id_pc_d;
            instr_q  <= instr_d;
            opcode_q <= opcode_d;
        end
    end

    // pc_q only moves on a completed transfer or while no request is up,
    // so the address stays stable for the whole request.
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_instr = instr_q;
    assign opcode      = opcode_q;

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage of the pipelined LEGv8 CPU.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Loads the IF/ID pipeline register and presents opcode = instruction[31:21] to the ID-stage control unit, i.e. it is the producer of the control unit's opcode input.
- Handles hazard-unit stalls, MEM-stage branch redirects and multi-cycle memory latency.

Parameters:
- ADDR_W, 64, PC / instruction-address width.
- RESET_PC, 0, PC value loaded on reset (word aligned).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard unit: hold IF/ID and the PC.
- branch_taken  in  1  MEM-stage PCSrc: redirect fetch and flush IF/ID.
- branch_target  in  ADDR_W  redirect address; bits [1:0] ignored and forced to 00.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory returns data this cycle; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  ADDR_W  PC of the IF/ID instruction.
- if_id_instr  out  32  IF/ID instruction word.
- opcode  out  11  if_id_instr[31:21] when if_id_valid=1, else 0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=0, opcode=0.
  - First request is issued on the first cycle after rst_n rises.
- Handshake:
  - Once imem_req=1, it stays high with imem_addr unchanged until imem_ack. No cancellation.
  - imem_ack while imem_req=0 is ignored.
- PC arithmetic: pc+4, wraps modulo 2^ADDR_W (all-ones-aligned PC wraps to 0).
- State FETCH (imem_req=1, imem_addr=pc):
  - ack & branch_taken: drop rdata; pc<=target; IF/ID valid<=0; stay FETCH.
  - ack & stall: buf<=rdata, buf_pc<=pc; pc<=pc+4; IF/ID held; go BUFFERED.
  - ack, no stall/branch: IF/ID<={pc, rdata, valid=1}; pc<=pc+4. Best case is one instruction per cycle.
  - no ack & branch_taken: pend<=target; IF/ID valid<=0; go DISCARD.
  - no ack & stall: IF/ID held.
  - no ack, otherwise: IF/ID valid<=0 (bubble).
- State BUFFERED (imem_req=0):
  - branch_taken: drop buf; pc<=target; IF/ID valid<=0; go FETCH.
  - stall=0: IF/ID<={buf_pc, buf, 1}; go FETCH.
  - else hold.
- State DISCARD (imem_req=1, imem_addr=old pc):
  - branch_taken updates pend (latest wins).
  - On ack: drop rdata; pc<=pend (or the same-cycle target); go FETCH.
  - IF/ID valid stays 0 throughout.
- Priority: branch_taken (flush) > stall > normal advance. A flush clears if_id_valid even while stall=1.
- if_id_pc and if_id_instr are don't-care when valid=0; opcode is forced to 0 when valid=0.
- Reset mid-transaction: returns to the reset state immediately. An ack arriving in the first cycle after reset is ignored because imem_req=0 in that cycle.

Test Plan:
- Zero-wait memory (ack same cycle), 4 cycles, no stall:
  - imem_addr sequence is 0,4,8,C.
  - IF/ID shows pc 0,4,8 with valid=1.
  - For instr 0xF8400000 (LDUR), opcode=0x7C2.
- Two-cycle memory latency:
  - imem_addr=0 is held for 2 cycles.
  - IF/ID valid alternates 0,1; pc advances only on ack.
- Stall asserted on the ack cycle for pc=8, for 3 cycles:
  - IF/ID holds its old contents; imem_req=0 while buffered.
  - After stall drops, IF/ID={8, word@8}; next request address is C.
- branch_taken with target 0x103 while a fetch of 0x10 is outstanding:
  - Word @0x10 never reaches IF/ID.
  - Next request address is 0x100; if_id_valid=0 until the new word arrives.
- branch_taken together with stall=1: if_id_valid=0 next cycle and opcode=0.
- PC wrap and reset:
  - Target 0xFFFF_FFFF_FFFF_FFFC followed by one ack gives next address 0.
  - rst_n pulsed low mid-wait: imem_req=0 immediately, then requests resume at RESET_PC.
